// File: rtl/fpm_pipe.sv
// fpm_pipe: three-stage floating-point multiplier with valid/ready handshaking.
// S1 unpacks and classifies the operands, S2 forms the mantissa product, and S3
// normalises, rounds (round-to-nearest-even) and packs the result and flags.
// A single global advance signal stalls every stage while the output is
// blocked, so in_ready depends only on the output handshake.
module fpm_pipe #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int unsigned EW2 = EXP_W + 2;       // signed working exponent width
    localparam int unsigned PW  = 2 * MAN_W + 2;   // full product width
    localparam int unsigned BIAS_I = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX_I = (1 << EXP_W) - 1;
    localparam logic [EW2-1:0] BIAS = EW2'(BIAS_I);
    localparam logic [EW2-1:0] EMAX = EW2'(EMAX_I);
    localparam logic [W-1:0]   QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic w_adv;

    // ---------------- S1 inputs: unpack and classify ----------------
    logic               w_sa, w_sb, w_sign;
    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [MAN_W-1:0]   w_ma, w_mb;
    logic               w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic               w_snan_a, w_snan_b;
    logic               w_spec, w_spec_inv;
    logic [W-1:0]       w_spec_res;
    logic [EW2-1:0]     w_exp1;

    logic               r1_valid, r1_sign, r1_spec, r1_spec_inv;
    logic [W-1:0]       r1_spec_res;
    logic [EW2-1:0]     r1_exp;
    logic [MAN_W:0]     r1_ma, r1_mb;

    logic               r2_valid, r2_sign, r2_spec, r2_spec_inv;
    logic [W-1:0]       r2_spec_res;
    logic [EW2-1:0]     r2_exp;
    logic [PW-1:0]      r2_prod;

    logic               r_out_valid;
    logic [W-1:0]       r_result;
    logic [3:0]         r_flags;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    assign {w_sa, w_ea, w_ma} = a;
    assign {w_sb, w_eb, w_mb} = b;
    assign w_sign = w_sa ^ w_sb;

    // Operand classification; subnormals fall into the zero class.
    always_comb begin
        w_zero_a = (w_ea == '0);
        w_zero_b = (w_eb == '0);
        w_inf_a  = (w_ea == '1) && (w_ma == '0);
        w_inf_b  = (w_eb == '1) && (w_mb == '0);
        w_nan_a  = (w_ea == '1) && (w_ma != '0);
        w_nan_b  = (w_eb == '1) && (w_mb != '0);
        w_snan_a = w_nan_a && !w_ma[MAN_W-1];
        w_snan_b = w_nan_b && !w_mb[MAN_W-1];
    end

    // Special-value resolution in priority order: NaN, Inf*0, Inf, zero.
    always_comb begin
        w_spec     = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_res = '0;
        if (w_nan_a || w_nan_b) begin
            w_spec_res = QNAN;
            w_spec_inv = w_snan_a || w_snan_b;
        end else if ((w_inf_a && w_zero_b) || (w_zero_a && w_inf_b)) begin
            w_spec_res = QNAN;
            w_spec_inv = 1'b1;
        end else if (w_inf_a || w_inf_b) begin
            w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_zero_a || w_zero_b) begin
            w_spec_res = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    // Biased exponent sum; two guard bits keep it signed without wrap.
    assign w_exp1 = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;

    // S1 register: classified operands, advancing only when the pipe moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
        end else if (w_adv) begin
            r1_valid    <= in_valid;
            r1_sign     <= w_sign;
            r1_spec     <= w_spec;
            r1_spec_inv <= w_spec_inv;
            r1_spec_res <= w_spec_res;
            r1_exp      <= w_exp1;
            r1_ma       <= {1'b1, w_ma};
            r1_mb       <= {1'b1, w_mb};
        end
    end

    // S2 register: mantissa product with hidden bits restored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
        end else if (w_adv) begin
            r2_valid    <= r1_valid;
            r2_sign     <= r1_sign;
            r2_spec     <= r1_spec;
            r2_spec_inv <= r1_spec_inv;
            r2_spec_res <= r1_spec_res;
            r2_exp      <= r1_exp;
            r2_prod     <= PW'(r1_ma) * PW'(r1_mb);
        end
    end

    // ---------------- S3: normalise, round, range check, pack ----------------
    logic [PW-2:0]  w_pn;
    logic [EW2-1:0] w_exp_n, w_exp_r;
    logic [MAN_W-1:0] w_man, w_man_r;
    logic           w_g, w_s, w_inc, w_carry, w_ovf, w_unf;
    logic [W-1:0]   w_res;
    logic [3:0]     w_flg;

    // Drop the hidden bit; a product below 2.0 is shifted up one place.
    always_comb begin
        if (r2_prod[PW-1]) begin
            w_pn    = r2_prod[PW-2:0];
            w_exp_n = r2_exp + EW2'(1);
        end else begin
            w_pn    = {r2_prod[PW-3:0], 1'b0};
            w_exp_n = r2_exp;
        end
        w_man = w_pn[PW-2 -: MAN_W];
        w_g   = w_pn[MAN_W];
        w_s   = |w_pn[MAN_W-1:0];
        w_inc = w_g && (w_s || w_man[0]);
        {w_carry, w_man_r} = {1'b0, w_man} + (MAN_W+1)'(w_inc);
        w_exp_r = w_exp_n + EW2'(w_carry);
        w_ovf   = !w_exp_r[EW2-1] && (w_exp_r >= EMAX);
        w_unf   = w_exp_r[EW2-1] || (w_exp_r == '0);
    end

    // Final result selection between special, overflow, underflow and normal.
    always_comb begin
        w_res = {r2_sign, w_exp_r[EXP_W-1:0], w_man_r};
        w_flg = {3'b000, w_g || w_s};
        if (r2_spec) begin
            w_res = r2_spec_res;
            w_flg = {r2_spec_inv, 3'b000};
        end else if (w_ovf) begin
            w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 4'b0101;
        end else if (w_unf) begin
            w_res = {r2_sign, {(W-1){1'b0}}};
            w_flg = 4'b0011;
        end
    end

    // S3 output register: holds result and flags stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_adv) begin
            r_out_valid <= r2_valid;
            if (r2_valid) begin
                r_result <= w_res;
                r_flags  <= w_flg;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_fpm_pipe.sv
// Self-checking bench for fpm_pipe (half-precision configuration).
// Table-driven products through a scoreboard, plus latency, back-pressure and
// mid-stream reset sequences.
module tb_fpm_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;

    fpm_pipe #(.EXP_W(5), .MAN_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  fl;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          first_acc = -1;
    int          first_out = -1;
    int          last_out  = -1;
    int          out_cnt   = 0;
    logic [19:0] cur_exp;
    logic [19:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Scoreboard: pushes expected values on input transfers, compares on output transfers.
    task automatic monitor();
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got result=%h flags=%b, required no output",
                                 result, flags);
                    end else begin
                        e = exp_q.pop_front();
                        if ({result, flags} !== e) begin
                            n_fail++;
                            $display("FAIL out[%0d]: got result=%h flags=%b, required result=%h flags=%b",
                                     out_cnt, result, flags, e[19:4], e[3:0]);
                        end
                    end
                    out_cnt++;
                    last_out = cyc;
                end
                if (out_valid && first_out < 0) first_out = cyc;
                if (in_valid && in_ready) begin
                    exp_q.push_back(cur_exp);
                    if (first_acc < 0) first_acc = cyc;
                end
            end
        end
    endtask

    // Offer one operand pair and return just after the edge that accepts it.
    task automatic send(input vec_t v);
        int n = 0;
        logic ok = 1'b0;
        a = v.a;
        b = v.b;
        cur_exp = {v.res, v.fl};
        in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            n++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required acceptance");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int base_cnt;
        int n;

        tbl[0]  = '{16'h3C00, 16'h4000, 16'h4000, 4'b0000};
        tbl[1]  = '{16'h3E00, 16'h3E00, 16'h4080, 4'b0000};
        tbl[2]  = '{16'hBE00, 16'h3E00, 16'hC080, 4'b0000};
        tbl[3]  = '{16'h3E00, 16'h3C01, 16'h3E02, 4'b0001};
        tbl[4]  = '{16'h3C01, 16'h3C01, 16'h3C02, 4'b0001};
        tbl[5]  = '{16'h3C03, 16'h3E00, 16'h3E04, 4'b0001};
        tbl[6]  = '{16'h3DA8, 16'h3DA8, 16'h4000, 4'b0001};
        tbl[7]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101};
        tbl[8]  = '{16'h7800, 16'h4000, 16'h7C00, 4'b0101};
        tbl[9]  = '{16'h7BFF, 16'h3C00, 16'h7BFF, 4'b0000};
        tbl[10] = '{16'h0400, 16'h0400, 16'h0000, 4'b0011};
        tbl[11] = '{16'h0400, 16'h3800, 16'h0000, 4'b0011};
        tbl[12] = '{16'h0400, 16'h3C00, 16'h0400, 4'b0000};
        tbl[13] = '{16'h8001, 16'h3C00, 16'h8000, 4'b0000};
        tbl[14] = '{16'h0000, 16'h8000, 16'h8000, 4'b0000};
        tbl[15] = '{16'h7C00, 16'h0000, 16'h7E00, 4'b1000};
        tbl[16] = '{16'h0000, 16'hFC00, 16'h7E00, 4'b1000};
        tbl[17] = '{16'h7D00, 16'h3C00, 16'h7E00, 4'b1000};
        tbl[18] = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b0000};
        tbl[19] = '{16'h7D00, 16'h0000, 16'h7E00, 4'b1000};
        tbl[20] = '{16'hFC00, 16'h4000, 16'hFC00, 4'b0000};
        tbl[21] = '{16'h7C00, 16'hFC00, 16'hFC00, 4'b0000};
        tbl[22] = '{16'hBC00, 16'hC000, 16'h4000, 4'b0000};
        tbl[23] = '{16'h7E00, 16'hFD01, 16'h7E00, 4'b1000};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cur_exp = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table vectors back-to-back with the consumer always ready
        base_cnt = out_cnt;
        for (int i = 0; i < NV; i++) send(tbl[i]);
        in_valid = 1'b0;
        drain();
        check("latency", 32'(first_out - first_acc), 32'd3);
        check("table_count", 32'(out_cnt - base_cnt), 32'(NV));
        check("consecutive", 32'(last_out - first_out), 32'(NV - 1));

        // Back-pressure: consumer stalls while five operands are offered
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        base_cnt = out_cnt;
        fork
            begin
                for (int i = 0; i < 5; i++) send(tbl[i]);
                in_valid = 1'b0;
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 50);
                check("bp_valid_seen", 32'(out_valid), 32'd1);
                for (int k = 0; k < 6; k++) begin
                    check("bp_in_ready_low", 32'(in_ready), 32'd0);
                    check("bp_hold_valid", 32'(out_valid), 32'd1);
                    check("bp_hold_result", 32'(result), 32'(tbl[0].res));
                    check("bp_hold_flags", 32'(flags), 32'(tbl[0].fl));
                    @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 32'(out_cnt - base_cnt), 32'd5);

        // Reset with two items in flight; stale results must never appear
        repeat (2) @(posedge clk);
        #1;
        base_cnt = out_cnt;
        send(tbl[1]);
        send(tbl[2]);
        rst = 1'b1;
        a = tbl[3].a;
        b = tbl[3].b;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_mid_no_stale", 32'(out_valid), 32'd0);
        end
        check("rst_mid_count", 32'(out_cnt - base_cnt), 32'd0);
        @(posedge clk);
        #1;
        send(tbl[3]);
        in_valid = 1'b0;
        drain();
        check("rst_recover_count", 32'(out_cnt - base_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
